// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: byte-serial loads and stores over the shared
// byte-wide RAM port, with mem-stage forwarding and a registered writeback port.
module mem_lsu #(
   parameter int         ADDR_W   = 32,
   parameter logic [6:0] LOAD_OP  = 7'b0000011,
   parameter logic [6:0] STORE_OP = 7'b0100011
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic [6:0]        opcode_i,
   input  logic [2:0]        funct3_i,
   input  logic              we_i,
   input  logic [4:0]        waddr_i,
   input  logic [31:0]       alu_i,
   input  logic [31:0]       sdata_i,
   output logic [6:0]        mem_opcode_o,
   output logic              mem_we_o,
   output logic [4:0]        mem_waddr_o,
   output logic [31:0]       mem_wdata_o,
   output logic              ram_req_o,
   input  logic              ram_gnt_i,
   output logic [ADDR_W-1:0] ram_a_o,
   output logic              ram_wr_o,
   output logic [7:0]        ram_dout_o,
   input  logic [7:0]        ram_din_i,
   output logic              stallreq_o,
   output logic              wb_we_o,
   output logic [4:0]        wb_waddr_o,
   output logic [31:0]       wb_wdata_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_GNT  = 2'd1;
   localparam logic [1:0] S_XFER = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] buf_q, buf_d;
   logic        wb_we_q;
   logic [4:0]  wb_waddr_q;
   logic [31:0] wb_wdata_q;

   logic        is_load, is_store;
   logic [2:0]  n_bytes;
   logic [1:0]  cap_sel;
   logic        issue, stall, req;
   logic [31:0] load_res;

   assign is_load  = (opcode_i == LOAD_OP);
   assign is_store = (opcode_i == STORE_OP);
   assign n_bytes  = (funct3_i[1:0] == 2'b00) ? 3'd1 :
                     (funct3_i[1:0] == 2'b01) ? 3'd2 : 3'd4;
   // Load data arrives one cycle after its address, so it belongs to byte cnt-1.
   assign cap_sel  = cnt_q[1:0] - 2'd1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      issue   = 1'b0;
      stall   = 1'b0;
      req     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (is_load || is_store) begin
               stall   = 1'b1;
               req     = 1'b1;
               state_d = S_GNT;
            end
         end
         S_GNT: begin
            stall = 1'b1;
            req   = 1'b1;
            if (ram_gnt_i) begin
               issue   = 1'b1;
               cnt_d   = 3'd1;
               state_d = (is_store && n_bytes == 3'd1) ? S_DONE : S_XFER;
            end
         end
         S_XFER: begin
            stall = 1'b1;
            req   = 1'b1;
            if (cnt_q < n_bytes) begin
               issue = 1'b1;
               cnt_d = cnt_q + 3'd1;
            end
            if (!is_store) begin
               buf_d[{cap_sel, 3'b000} +: 8] = ram_din_i;
            end
            if (is_store ? (cnt_q == n_bytes - 3'd1) : (cnt_q == n_bytes)) begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   always_comb begin
      case (funct3_i)
         3'b000:  load_res = {{24{buf_q[7]}}, buf_q[7:0]};
         3'b001:  load_res = {{16{buf_q[15]}}, buf_q[15:0]};
         3'b100:  load_res = {24'd0, buf_q[7:0]};
         3'b101:  load_res = {16'd0, buf_q[15:0]};
         default: load_res = buf_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 3'd0;
         buf_q      <= 32'd0;
         wb_we_q    <= 1'b0;
         wb_waddr_q <= 5'd0;
         wb_wdata_q <= 32'd0;
      end else if (rdy) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         if (state_q == S_DONE) begin
            wb_we_q    <= we_i;
            wb_waddr_q <= waddr_i;
            wb_wdata_q <= is_load ? load_res : alu_i;
         end else if (stall) begin
            wb_we_q <= 1'b0;
         end else begin
            wb_we_q    <= we_i;
            wb_waddr_q <= waddr_i;
            wb_wdata_q <= alu_i;
         end
      end
   end

   // Combinational handshakes are forced low while reset is held so an abort is immediate.
   assign stallreq_o = rst & stall;
   assign ram_req_o  = rst & req;
   assign ram_wr_o   = rst & issue & is_store;
   assign ram_a_o    = (rst && (state_q == S_GNT || state_q == S_XFER)) ?
                       alu_i[ADDR_W-1:0] + ADDR_W'(cnt_q) : '0;
   assign ram_dout_o = sdata_i[{cnt_q[1:0], 3'b000} +: 8];

   assign mem_opcode_o = opcode_i;
   assign mem_we_o     = we_i;
   assign mem_waddr_o  = waddr_i;
   assign mem_wdata_o  = alu_i;

   assign wb_we_o    = wb_we_q;
   assign wb_waddr_o = wb_waddr_q;
   assign wb_wdata_o = wb_wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu: byte-addressed RAM and arbiter models, with
// expected load results and store contents computed from plain arithmetic.
module tb_mem_lsu;

   localparam logic [6:0] LOAD_OP  = 7'b0000011;
   localparam logic [6:0] STORE_OP = 7'b0100011;
   localparam logic [6:0] ALU_OP   = 7'b0110011;

   logic        clk, rst, rdy;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] alu, sdata;
   logic        gnt;
   logic [7:0]  din;

   logic [6:0]  mem_opcode_o;
   logic        mem_we_o;
   logic [4:0]  mem_waddr_o;
   logic [31:0] mem_wdata_o;
   logic        ram_req_o, ram_wr_o, stallreq_o;
   logic [31:0] ram_a_o;
   logic [7:0]  ram_dout_o;
   logic        wb_we_o;
   logic [4:0]  wb_waddr_o;
   logic [31:0] wb_wdata_o;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] mem [logic [31:0]];

   mem_lsu dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .opcode_i(opcode), .funct3_i(funct3), .we_i(we), .waddr_i(waddr),
      .alu_i(alu), .sdata_i(sdata),
      .mem_opcode_o(mem_opcode_o), .mem_we_o(mem_we_o),
      .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
      .ram_req_o(ram_req_o), .ram_gnt_i(gnt), .ram_a_o(ram_a_o),
      .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o), .ram_din_i(din),
      .stallreq_o(stallreq_o),
      .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 8'h00;
   endfunction

   // Byte RAM: writes land on the edge, read data appears one cycle after its address.
   always @(posedge clk) begin
      if (rst && rdy) begin
         if (ram_wr_o && gnt) mem[ram_a_o] = ram_dout_o;
         din <= mem_rd(ram_a_o);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int nbytes(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] load_model(input logic [31:0] a, input logic [2:0] f3);
      longint raw = 0;
      int n = nbytes(f3);
      for (int j = 0; j < n; j++) raw = raw + (longint'(mem_rd(a + j)) << (8 * j));
      if (n < 4 && !f3[2] && raw >= (longint'(1) << (8 * n - 1)))
         raw = raw - (longint'(1) << (8 * n));
      return raw[31:0];
   endfunction

   task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic we_v,
                        input logic [4:0] wa, input logic [31:0] a, input logic [31:0] sd,
                        input int gdelay, input bit pause_req);
      int n, k, pause_at, stall_cnt, exp_stall;
      bit is_ld, is_st, pause, early_wr, bubble_bad, hold_bad;
      logic [31:0] exp_data, hold_a, sd_sh;
      logic [7:0]  after_byte;
      is_ld = (op == LOAD_OP);
      is_st = (op == STORE_OP);
      pause = pause_req && is_ld;
      n = nbytes(f3);
      exp_data = is_ld ? load_model(a, f3) : a;
      after_byte = mem_rd(a + n);
      opcode = op; funct3 = f3; we = we_v; waddr = wa; alu = a; sdata = sd;
      gnt = 1'b0; rdy = 1'b1;
      if (!is_ld && !is_st) begin
         #1;
         chk("alu_stall", {31'd0, stallreq_o}, 32'd0);
         chk("fwd_wdata", mem_wdata_o, a);
         @(negedge clk);
         chk("alu_wb_we", {31'd0, wb_we_o}, {31'd0, we_v});
         chk("alu_wb_waddr", {27'd0, wb_waddr_o}, {27'd0, wa});
         chk("alu_wb_wdata", wb_wdata_o, a);
         $display("txn alu we=%0d rd=%0d wdata=%08h", we_v, wa, wb_wdata_o);
         return;
      end
      pause_at = pause ? 2 + gdelay : -1;
      k = 0; stall_cnt = 0; early_wr = 0; bubble_bad = 0; hold_bad = 0; hold_a = '0;
      while (k < 100) begin
         gnt = (k >= 1 + gdelay);
         rdy = !(pause && k >= pause_at && k < pause_at + 2);
         #1;
         if (!stallreq_o) break;
         if (!gnt && ram_wr_o) early_wr = 1;
         if (k >= 1 && wb_we_o) bubble_bad = 1;
         if (pause && k == pause_at) hold_a = ram_a_o;
         if (pause && (k == pause_at + 1 || k == pause_at + 2) && ram_a_o !== hold_a) hold_bad = 1;
         stall_cnt++;
         @(negedge clk);
         k++;
      end
      gnt = 1'b0;
      rdy = 1'b1;
      chk("timeout", {31'd0, k < 100}, 32'd1);
      exp_stall = 1 + gdelay + n + (is_ld ? 1 : 0) + (pause ? 2 : 0);
      chk("stall_cycles", stall_cnt, exp_stall);
      chk("done_req", {31'd0, ram_req_o}, 32'd0);
      chk("bubble", {31'd0, bubble_bad}, 32'd0);
      if (is_st) chk("early_wr", {31'd0, early_wr}, 32'd0);
      if (pause) chk("rdy_hold_addr", {31'd0, hold_bad}, 32'd0);
      @(negedge clk);
      chk("wb_we", {31'd0, wb_we_o}, {31'd0, we_v});
      chk("wb_waddr", {27'd0, wb_waddr_o}, {27'd0, wa});
      chk("wb_wdata", wb_wdata_o, exp_data);
      if (is_st) begin
         for (int j = 0; j < n; j++) begin
            sd_sh = sd >> (8 * j);
            chk("st_byte", {24'd0, mem_rd(a + j)}, {24'd0, sd_sh[7:0]});
         end
         chk("st_after", {24'd0, mem_rd(a + n)}, {24'd0, after_byte});
      end
      $display("txn %s f3=%0d addr=%08h gdly=%0d pause=%0d stall=%0d wb=%08h",
               is_ld ? "load" : "store", f3, a, gdelay, pause, stall_cnt, wb_wdata_o);
   endtask

   task automatic reset_abort();
      opcode = LOAD_OP; funct3 = 3'b010; we = 1'b1; waddr = 5'd7; alu = 32'h100;
      gnt = 1'b1; rdy = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("pre_rst_in_xfer", {31'd0, stallreq_o}, 32'd1);
      rst = 1'b0;
      #1;
      chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
      chk("rst_req", {31'd0, ram_req_o}, 32'd0);
      chk("rst_wr", {31'd0, ram_wr_o}, 32'd0);
      chk("rst_wb_we", {31'd0, wb_we_o}, 32'd0);
      chk("rst_wb_waddr", {27'd0, wb_waddr_o}, 32'd0);
      chk("rst_wb_wdata", wb_wdata_o, 32'd0);
      @(negedge clk);
      rst = 1'b1; gnt = 1'b0;
      opcode = ALU_OP; we = 1'b1; waddr = 5'd3; alu = 32'h55;
      #1;
      chk("post_rst_idle", {31'd0, stallreq_o}, 32'd0);
      @(negedge clk);
      chk("post_rst_wb", wb_wdata_o, 32'h55);
      $display("txn reset-abort during load, wb after release=%08h", wb_wdata_o);
   endtask

   initial begin
      logic [2:0]  ld_f3 [5];
      logic [2:0]  f3;
      logic [6:0]  op;
      logic [31:0] a;
      int sel;
      ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010;
      ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
      rst = 1'b0; rdy = 1'b1; gnt = 1'b0;
      opcode = 7'd0; funct3 = 3'd0; we = 1'b0; waddr = 5'd0; alu = 32'd0; sdata = 32'd0;
      mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
      mem[32'h20]  = 8'h80;
      mem[32'h40]  = 8'h00; mem[32'h41]  = 8'h80;
      for (int i = 0; i < 256; i++) mem[32'h1000 + i] = 8'($urandom);
      for (int i = -8; i < 8; i++) mem[32'(i)] = 8'($urandom);
      repeat (2) @(negedge clk);
      #1;
      chk("reset_stall", {31'd0, stallreq_o}, 32'd0);
      chk("reset_req", {31'd0, ram_req_o}, 32'd0);
      chk("reset_wb_we", {31'd0, wb_we_o}, 32'd0);
      chk("reset_wb_wdata", wb_wdata_o, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      do_op(ALU_OP,   3'b000, 1'b1, 5'd5, 32'h1234,   32'h0,    0, 0);
      do_op(LOAD_OP,  3'b010, 1'b1, 5'd6, 32'h100,    32'h0,    0, 0);
      do_op(LOAD_OP,  3'b000, 1'b1, 5'd8, 32'h20,     32'h0,    1, 0);
      do_op(LOAD_OP,  3'b100, 1'b1, 5'd9, 32'h20,     32'h0,    0, 0);
      do_op(LOAD_OP,  3'b001, 1'b1, 5'd10, 32'h40,    32'h0,    2, 0);
      do_op(STORE_OP, 3'b001, 1'b0, 5'd0, 32'h3FFFF,  32'hABCD, 3, 0);
      do_op(LOAD_OP,  3'b010, 1'b1, 5'd11, 32'h100,   32'h0,    0, 1);
      do_op(ALU_OP,   3'b000, 1'b1, 5'd5, 32'h1234,   32'h0,    0, 0);
      reset_abort();

      for (int t = 0; t < 40; t++) begin
         sel = $urandom_range(0, 2);
         a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3)
                                         : 32'h1000 + $urandom_range(0, 250);
         if (sel == 0) begin
            op = ALU_OP; f3 = 3'($urandom);
         end else if (sel == 1) begin
            op = LOAD_OP; f3 = ld_f3[$urandom_range(0, 4)];
         end else begin
            op = STORE_OP; f3 = 3'($urandom_range(0, 2));
         end
         do_op(op, f3, (sel == 2) ? 1'b0 : 1'($urandom), 5'($urandom), a, $urandom,
               $urandom_range(0, 3), 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-stage load/store unit; sits between the ex_mem pipeline register and mem_wb.
- Performs byte-serial loads and stores over the shared byte-wide RAM port, with arbitration against instruction fetch.
- Drives the regfile's mem-stage forwarding inputs and the writeback port (wb_we/wb_waddr/wb_wdata) that the regfile writes from.
- Stalls the pipeline while a memory access is in flight.

Parameters:
- ADDR_W, 32, RAM address width
- LOAD_OP, 7'b0000011, load opcode
- STORE_OP, 7'b0100011, store opcode

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global pause; when low, all state and outputs hold
- opcode_i  in  7  opcode from ex_mem
- funct3_i  in  3  access size/sign
- we_i  in  1  instruction writes rd
- waddr_i  in  5  rd
- alu_i  in  32  ALU result; effective address for load/store
- sdata_i  in  32  store data (rs2)
- mem_opcode_o  out  7  to regfile forwarding, equals opcode_i
- mem_we_o  out  1  to regfile, equals we_i
- mem_waddr_o  out  5  to regfile, equals waddr_i
- mem_wdata_o  out  32  to regfile, equals alu_i
- ram_req_o  out  1  request RAM port from arbiter
- ram_gnt_i  in  1  port granted this cycle
- ram_a_o  out  ADDR_W  byte address
- ram_wr_o  out  1  1 = write byte
- ram_dout_o  out  8  write byte
- ram_din_i  in  8  read byte, valid one cycle after its address
- stallreq_o  out  1  to stallctrl
- wb_we_o  out  1  registered, to mem_wb/regfile
- wb_waddr_o  out  5  registered
- wb_wdata_o  out  32  registered

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, assembly buffer=0. All registered outputs 0. ram_req_o=0, ram_wr_o=0, stallreq_o=0.
- N = 1/2/4 for funct3[1:0] = 00/01/10. funct3[1:0]=11 is treated as N=4.
- IDLE:
  - opcode_i ∈ {LOAD_OP, STORE_OP}: stallreq_o=1 combinationally, ram_req_o=1; next state is GNT.
  - Otherwise: on each rdy edge, wb_we_o<=we_i, wb_waddr_o<=waddr_i, wb_wdata_o<=alu_i.
- GNT: hold ram_req_o=1, stallreq_o=1.
  - ram_gnt_i=1: drive byte 0 the same cycle (ram_a_o=alu_i, ram_wr_o=store, ram_dout_o=sdata_i[7:0]); cnt<=1; go XFER.
- XFER: ram_req_o=1, stallreq_o=1.
  - While cnt<N: ram_a_o=alu_i+cnt; store drives byte cnt of sdata_i; cnt++.
  - Loads: ram_din_i sampled each cycle after an address, stored into byte cnt-1 of the buffer.
  - Store done: after byte N-1 is issued, go DONE. N cycles from grant.
  - Load done: after byte N-1 data is captured, go DONE. N+1 cycles from grant.
  - A grant drop mid-XFER is not permitted; the arbiter holds the grant while req=1.
- DONE: ram_req_o=0, stallreq_o=0 for exactly one cycle, letting the pipeline advance.
  - On this edge: wb_we_o<=we_i.
  - wb_wdata_o <= load result: LB/LH sign-extended, LBU/LHU zero-extended, LW raw; for stores, alu_i.
  - Go IDLE.
- While stallreq_o=1, wb_we_o<=0 on each rdy edge (bubble into mem_wb).
- Byte order is little-endian: byte k ↔ bits [8k+7:8k].
- Address addition is modulo 2^ADDR_W (wrap).
- rdy=0: the FSM, cnt and buffer freeze; RAM outputs hold their values.
- Reset mid-transfer aborts immediately. No partial writeback; a partial store may remain in RAM.
- x0 writes are filtered by the regfile, not here.

Test Plan:
- ALU op (opcode 0110011, we=1, waddr=5, alu=0x1234) → next edge wb_we_o=1, wb_waddr_o=5, wb_wdata_o=0x1234; stallreq_o stays 0.
- LW at 0x100, gnt immediate, RAM bytes 0x78,0x56,0x34,0x12 → addresses 0x100..0x103 on consecutive cycles; stallreq_o high 6 cycles; wb_wdata_o=0x12345678.
- LB at 0x20 with byte 0x80 → wb_wdata_o=0xFFFFFF80. LBU of the same byte → 0x00000080. LH with bytes 0x00,0x80 → 0xFFFF8000.
- SH at 0x3FFFF, sdata=0xABCD, gnt delayed 3 cycles → no RAM write before grant; then writes 0xCD@0x3FFFF, 0xAB@0x40000; wb_we_o=0 throughout.
- rdy=0 for 2 cycles in the middle of an LW → ram_a_o held, result unchanged (0x12345678).
- rst=0 asserted during XFER → all outputs 0 asynchronously; after release the FSM is in IDLE.
